// File: rtl/fifo_out_pkg.sv
// Shared definitions for the result output FIFO and its drain-side reader.
package fifo_out_pkg;

  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned DCNT_W     = 6;
  localparam int unsigned RD_CNT_W   = 16;

  // Existing FIFO controller state codes; RD_ERROR is the source of fifo_rd_err.
  typedef enum logic [2:0] {
    FIFO_IDLE     = 3'b000,
    FIFO_WRITE    = 3'b001,
    FIFO_READ     = 3'b010,
    FIFO_WR_ERROR = 3'b011,
    FIFO_RD_ERROR = 3'b100
  } fifo_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    LOAD = 2'b10,
    HOLD = 2'b11
  } rd_state_e;

  function automatic logic fifo_is_rd_err(input fifo_state_e s);
    return (s == FIFO_RD_ERROR);
  endfunction

endpackage

// File: rtl/fifo_out_reader_if.sv
// Valid/ready output stream from the FIFO reader to its consumer.
interface fifo_out_reader_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_out_rd_cnt.sv
// Wrapping counter of accepted output words (handshake counter).
module fifo_out_rd_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_out_reader.sv
// Drain-side reader for the output FIFO: pop, capture, present on valid/ready.
// Define FIFO_OUT_RD_CNT_EN to enable the rd_count accepted-word counter.
module fifo_out_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DCNT_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              drain_en,
  input  logic [DCNT_W-1:0] data_count,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_rd_err,
  output logic              rd_en,
  fifo_out_reader_if.master m_if,
  output logic              err_flag,
  input  logic              err_clr,
  output logic [15:0]       rd_count
);

  import fifo_out_pkg::*;

  rd_state_e         state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              err_q, err_d;
  logic              can_pop;

  // data_count already reflects any pop retired on the previous edge.
  assign can_pop = drain_en && (data_count != '0);

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    err_d    = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      IDLE: if (can_pop) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        // Set is evaluated after clear so a simultaneous underflow wins.
        if (fifo_rd_err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          m_data_d = fifo_dout;
          state_d  = HOLD;
        end
      end
      HOLD: if (m_if.m_ready) state_d = can_pop ? POP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      err_q    <= err_d;
    end
  end

  assign rd_en       = (state_q == POP);
  assign m_if.m_valid = (state_q == HOLD);
  assign m_if.m_data  = m_data_q;
  assign err_flag    = err_q;

`ifdef FIFO_OUT_RD_CNT_EN
  fifo_out_rd_cnt #(.CNT_W(16)) u_rd_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (m_if.m_valid && m_if.m_ready),
    .count   (rd_count)
  );
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_out_reader.sv
// Self-checking bench for fifo_out_reader: FIFO modelled as a queue, output stream
// checked against the in-order list of pushed words.
module tb_fifo_out_reader;

  localparam int unsigned DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        drain_en = 1'b0;
  logic [5:0]  data_count = '0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_err = 1'b0;
  logic        rd_en;
  logic        err_flag;
  logic        err_clr = 1'b0;
  logic [15:0] rd_count;

  fifo_out_reader_if #(.DATA_W(DATA_W)) m_bus ();

  fifo_out_reader #(.DATA_W(DATA_W), .DCNT_W(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .drain_en    (drain_en),
    .data_count  (data_count),
    .fifo_dout   (fifo_dout),
    .fifo_rd_err (fifo_rd_err),
    .rd_en       (rd_en),
    .m_if        (m_bus),
    .err_flag    (err_flag),
    .err_clr     (err_clr),
    .rd_count    (rd_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pops = 0;
  int accepted = 0;
  int last_pop = -1;
  bit strict_gap = 1'b0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    data_count = 6'(fifo_q.size());
  endtask

  // One clock: observe the cycle's handshake/pop, take the edge, update FIFO model.
  task automatic clk_cycle();
    logic        rd_pre, hs_pre;
    logic [31:0] d_pre;
    logic [31:0] want;
    rd_pre = rd_en;
    hs_pre = m_bus.m_valid && m_bus.m_ready;
    d_pre  = m_bus.m_data;
    if (hs_pre) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("stream_word", d_pre, want);
      end
      accepted++;
    end
    if (rd_pre) begin
      check("pop_nonempty", 32'(data_count != '0), 32'd1);
      if (last_pop >= 0) begin
        if (strict_gap) check("pop_gap", 32'(cyc - last_pop), 32'd3);
        else            check("pop_gap_min", 32'(cyc - last_pop >= 3), 32'd1);
      end
      pops++;
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pre) fifo_dout = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hBAD0_BAD0;
    data_count = 6'(fifo_q.size());
  endtask

  task automatic run_until_rd(input string tag, input int budget);
    int n = 0;
    while (rd_en !== 1'b1 && n < budget) begin
      clk_cycle();
      n++;
    end
    check(tag, 32'(rd_en), 32'd1);
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      clk_cycle();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    int a0;
    logic [15:0] cnt0;

    m_bus.m_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_m_valid", 32'(m_bus.m_valid), 32'd0);
    check("rst_m_data", m_bus.m_data, 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    clk_cycle();

    // Single word: latency and one rd_en pulse
    drain_en = 1'b1;
    p0 = pops;
    push(32'h0000_0078);
    n = 0;
    while (m_bus.m_valid !== 1'b1 && n < 10) begin
      clk_cycle();
      n++;
    end
    check("single_latency", 32'(n), 32'd3);
    check("single_data", m_bus.m_data, 32'h78);
    check("single_pops", 32'(pops - p0), 32'd1);
    m_bus.m_ready = 1'b1;
    clk_cycle();
    check("single_idle_valid", 32'(m_bus.m_valid), 32'd0);
    repeat (4) clk_cycle();
    check("single_no_extra_pop", 32'(pops - p0), 32'd1);

    // Back-pressure on the second of three words
    p0 = pops;
    push(32'h1); push(32'h2); push(32'h6);
    n = 0;
    while (!(m_bus.m_valid === 1'b1 && m_bus.m_data === 32'h2) && n < 30) begin
      clk_cycle();
      n++;
    end
    check("bp_reach_word2", m_bus.m_data, 32'h2);
    m_bus.m_ready = 1'b0;
    repeat (5) begin
      clk_cycle();
      check("bp_hold_data", m_bus.m_data, 32'h2);
      check("bp_hold_valid", 32'(m_bus.m_valid), 32'd1);
      check("bp_no_pop", 32'(rd_en), 32'd0);
    end
    m_bus.m_ready = 1'b1;
    run_until_drained("bp_drain", 30);
    check("bp_pops", 32'(pops - p0), 32'd3);

    // Full FIFO drain, pops exactly 3 cycles apart
    cnt0 = rd_count;
    p0 = pops;
    for (int i = 0; i < 32; i++) push($urandom);
    check("full_count", 32'(data_count), 32'd32);
    strict_gap = 1'b1;
    last_pop = -1;
    run_until_drained("full_drain", 200);
    strict_gap = 1'b0;
    repeat (6) clk_cycle();
    check("full_pops", 32'(pops - p0), 32'd32);
`ifdef FIFO_OUT_RD_CNT_EN
    check("full_rd_count", 32'(rd_count - cnt0), 32'd32);
`else
    check("full_rd_count", 32'(rd_count), 32'd0);
`endif

    // Underflow: error sets flag, word discarded
    push(32'hAAAA_0001);
    run_until_rd("uf1_pop", 10);
    clk_cycle();
    fifo_rd_err = 1'b1;
    void'(exp_q.pop_front());
    clk_cycle();
    fifo_rd_err = 1'b0;
    check("uf1_valid", 32'(m_bus.m_valid), 32'd0);
    check("uf1_err", 32'(err_flag), 32'd1);
    clk_cycle();
    check("uf1_err_sticky", 32'(err_flag), 32'd1);
    // Pops continue while err_flag is set; set beats clear
    push(32'hAAAA_0002);
    run_until_rd("uf2_pop", 10);
    clk_cycle();
    fifo_rd_err = 1'b1;
    err_clr = 1'b1;
    void'(exp_q.pop_front());
    clk_cycle();
    fifo_rd_err = 1'b0;
    check("uf2_set_wins", 32'(err_flag), 32'd1);
    clk_cycle();
    err_clr = 1'b0;
    check("uf2_clear", 32'(err_flag), 32'd0);
    check("uf2_valid", 32'(m_bus.m_valid), 32'd0);

    // drain_en dropped during LOAD
    p0 = pops;
    for (int i = 0; i < 10; i++) push(32'hC000_0000 + 32'(i));
    run_until_rd("de_pop", 10);
    clk_cycle();
    drain_en = 1'b0;
    a0 = accepted;
    repeat (8) clk_cycle();
    check("de_one_word", 32'(accepted - a0), 32'd1);
    check("de_one_pop", 32'(pops - p0), 32'd1);
    check("de_count", 32'(data_count), 32'd9);
    check("de_idle_valid", 32'(m_bus.m_valid), 32'd0);
    drain_en = 1'b1;
    run_until_drained("de_resume", 60);
    check("de_pops", 32'(pops - p0), 32'd10);

    // Random pushes, back-pressure and drain_en toggling
    for (int i = 0; i < 400; i++) begin
      m_bus.m_ready = ($urandom_range(0, 2) != 0);
      drain_en = ($urandom_range(0, 3) != 0);
      clk_cycle();
      if (fifo_q.size() < 32 && $urandom_range(0, 3) == 0) push($urandom);
    end
    drain_en = 1'b1;
    m_bus.m_ready = 1'b1;
    run_until_drained("rand_drain", 200);
    repeat (3) clk_cycle();
`ifdef FIFO_OUT_RD_CNT_EN
    check("final_rd_count", 32'(rd_count), 32'(accepted[15:0]));
`else
    check("final_rd_count", 32'(rd_count), 32'd0);
`endif

    // Asynchronous reset while holding a word
    m_bus.m_ready = 1'b0;
    push(32'h0000_DEAD);
    n = 0;
    while (m_bus.m_valid !== 1'b1 && n < 10) begin
      clk_cycle();
      n++;
    end
    check("hold_dead", m_bus.m_data, 32'h0000_DEAD);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_bus.m_valid), 32'd0);
    check("arst_data", m_bus.m_data, 32'd0);
    check("arst_err", 32'(err_flag), 32'd0);
    check("arst_rd_en", 32'(rd_en), 32'd0);
    check("arst_rd_count", 32'(rd_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_out_reader.md
Name: fifo_out_reader

Overview:
Drain-side controller for the result output FIFO (depth 32, 6-bit data_count). Issues single-cycle rd_en pops and captures FIFO read data one cycle later. Presents each word on a valid/ready stream to the downstream consumer (bus slave / display logic). Never pops an empty FIFO under normal operation. Reports a sticky error if the FIFO signals a read underflow.

Parameters:
DATA_W, 32, width of FIFO read data and m_data
DCNT_W, 6, width of FIFO data_count (0..32)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
drain_en  in  1  1 = reader allowed to start new pops
data_count  in  DCNT_W  FIFO occupancy, updated on the clk edge ending a pop/push
fifo_dout  in  DATA_W  FIFO read data, valid in the cycle after the rd_en cycle
fifo_rd_err  in  1  FIFO is in its read-error state (pop attempted while empty)
rd_en  out  1  FIFO pop request, one cycle wide
m_valid  out  1  output word valid
m_data  out  DATA_W  output word
m_ready  in  1  consumer accepts word when m_valid&m_ready
err_flag  out  1  sticky underflow indicator
err_clr  in  1  synchronous clear of err_flag
rd_count  out  16  accepted-word counter (see Optional Feature)

Behaviour:
- Reset (reset_n=0, async): state=IDLE; rd_en=0, m_valid=0, m_data=0, err_flag=0, rd_count=0. A pop in flight at reset is lost; the FIFO has already decremented. This is accepted behaviour.
- FSM encoding is 2-bit: IDLE=00, POP=01, LOAD=10, HOLD=11. All outputs are registered or Moore-decoded from state. No combinational input-to-output path except m_ready into the next state.
- IDLE: rd_en=0, m_valid=0. If drain_en=1 and data_count!=0, go to POP. Otherwise stay in IDLE.
- POP: rd_en=1 for exactly this cycle. Unconditionally go to LOAD.
- LOAD: rd_en=0, m_valid=0.
  - If fifo_rd_err=1: discard fifo_dout, set err_flag, go to IDLE.
  - Else: m_data<=fifo_dout at the clock edge, go to HOLD.
- HOLD: m_valid=1; m_data is stable until the handshake.
  - If m_ready=0: stay in HOLD.
  - If m_ready=1, drain_en=1 and data_count!=0: go to POP.
  - If m_ready=1 otherwise: go to IDLE.
- Throughput: at most 1 word per 3 cycles (POP, LOAD, HOLD). Latency from IDLE with data available to m_valid is 3 edges.
- drain_en deasserted mid-transfer: the current word completes (POP→LOAD→HOLD→handshake). No new pop is started afterwards.
- data_count sampled in IDLE/HOLD already reflects the previous pop, so the reader does not over-pop. A concurrent writer push only raises data_count. The reader tolerates one-cycle staleness because count never overstates occupancy.
- data_count==32 (full) is treated like any non-zero value.
- err_flag:
  - set by the LOAD&fifo_rd_err condition;
  - cleared by err_clr=1;
  - if set and clear occur in the same cycle, set wins;
  - err_flag does not block further pops.
- m_data is unchanged outside the LOAD→HOLD capture edge.

Optional Feature:
FIFO_OUT_RD_CNT_EN
- Defined: rd_count increments by 1 on every cycle with m_valid&m_ready=1. It wraps 16'hFFFF→0 and resets to 0. It is not affected by err_clr.
- Not defined: the rd_count port still exists and is tied to 16'h0000, so the interface is unchanged. No counter flops are inferred.

Decomposition:
- Shared package fifo_out_pkg holds:
  - FIFO_DEPTH=32 and DCNT_W=6;
  - the existing FIFO state codes (IDLE 000, WRITE 001, READ 010, WR_ERROR 011, RD_ERROR 100), used to derive fifo_rd_err at the top level;
  - the reader FSM codes above.
- One sub-module: fifo_out_rd_cnt (16-bit wrapping handshake counter). It is instantiated only when FIFO_OUT_RD_CNT_EN is defined.

Test Plan:
- Reset mid-HOLD: drive m_data=0xDEAD, then reset_n=0 → m_valid=0, m_data=0 and err_flag=0 immediately, with no clk edge needed.
- Single word: data_count=1, fifo_dout=0x0000_0078 in the LOAD cycle, drain_en=1, m_ready=1 → rd_en high exactly 1 cycle; m_valid rises 3 edges after start; m_data=0x78; return to IDLE when data_count=0.
- Back-pressure: 3 words (0x1, 0x2, 0x6), m_ready=0 for 5 cycles on word 2 → m_data holds 0x2 and rd_en stays 0 throughout. Exactly 3 pops in total; words arrive in order.
- Full drain: data_count=32, m_ready=1 → 32 rd_en pulses, each 3 cycles apart; no pop when data_count=0; rd_count=32 with FIFO_OUT_RD_CNT_EN, 0 without.
- Underflow: fifo_rd_err=1 in LOAD → m_valid stays 0, err_flag=1; with err_clr=1 and a new underflow in the same cycle, err_flag stays 1; err_clr alone → 0.
- drain_en drop: deassert drain_en in LOAD with data_count=10 → the current word is delivered, then IDLE with no further rd_en; reassert → pops resume.
